// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
//
// Single push-button conditioner. The raw pin is brought into the i_clk domain
// by a two-flop synchroniser. A four-state FSM then filters contact bounce:
// the synchronised key must stay at the new level for P_DEBOUNCE_CNT
// consecutive cycles before a press or release is accepted. A hold counter
// runs while the key is firmly pressed and fires a single long-press pulse.
//
// Parameters
//   P_KEY_ON        pin level that means "pressed" (0 or 1)
//   P_DEBOUNCE_CNT  stable cycles needed to accept a press or release (>= 1)
//   P_LONG_CNT      cycles held in PRESSED before o_long_press; 0 disables it
//
// Ports
//   i_clk          system clock
//   i_rst          asynchronous, active-high reset
//   i_key          raw, asynchronous button pin
//   o_key_state    debounced level, 1 = pressed
//   o_key_press    one-cycle pulse on an accepted press
//   o_key_release  one-cycle pulse on an accepted release
//   o_long_press   one-cycle pulse, at most once per press
//   o_press_cnt    accepted press count, wraps 255 -> 0
// -----------------------------------------------------------------------------
module key_debounce #(
  parameter bit          P_KEY_ON       = 1'b1,
  parameter int unsigned P_DEBOUNCE_CNT = 20000,
  parameter int unsigned P_LONG_CNT     = 1000000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_key,
  output logic       o_key_state,
  output logic       o_key_press,
  output logic       o_key_release,
  output logic       o_long_press,
  output logic [7:0] o_press_cnt
);

  localparam logic        KEY_OFF   = ~P_KEY_ON;
  localparam logic [31:0] DEB_LAST  = 32'(P_DEBOUNCE_CNT - 1);
  // With P_LONG_CNT = 0 this wraps to all ones; it is then only a harmless
  // saturation point because LONG_EN blocks the pulse.
  localparam logic [31:0] LONG_LAST = 32'(P_LONG_CNT - 1);
  localparam bit          LONG_EN   = (P_LONG_CNT != 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS_FILT,
    S_PRESSED,
    S_REL_FILT
  } state_t;

  logic        sync1_q, sync2_q;
  logic        key_k;

  state_t      state_q,       state_d;
  logic [31:0] deb_cnt_q,     deb_cnt_d;
  logic [31:0] hold_cnt_q,    hold_cnt_d;
  logic        long_done_q,   long_done_d;
  logic        key_state_q,   key_state_d;
  logic        press_q,       press_d;
  logic        release_q,     release_d;
  logic        long_q,        long_d;
  logic [7:0]  press_cnt_q,   press_cnt_d;

  // Synchroniser resets to the released level so leaving reset can never look
  // like a key edge.
  // NOTE: sequential blocks use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1_q <= KEY_OFF;
      sync2_q <= KEY_OFF;
    end else begin
      sync1_q <= i_key;
      sync2_q <= sync1_q;
    end
  end

  // Normalised key: 1 = pressed regardless of pin polarity.
  assign key_k = (sync2_q == P_KEY_ON);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      deb_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      long_done_q <= 1'b0;
      key_state_q <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
      press_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      deb_cnt_q   <= deb_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      long_done_q <= long_done_d;
      key_state_q <= key_state_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
      press_cnt_q <= press_cnt_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    deb_cnt_d   = deb_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    long_done_d = long_done_q;
    key_state_d = key_state_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;
    press_cnt_d = press_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (key_k) begin
          state_d   = S_PRESS_FILT;
          deb_cnt_d = '0;
        end
      end

      S_PRESS_FILT: begin
        if (!key_k) begin
          state_d = S_IDLE;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d     = S_PRESSED;
          press_d     = 1'b1;
          key_state_d = 1'b1;
          press_cnt_d = press_cnt_q + 8'd1;
          hold_cnt_d  = '0;
          long_done_d = 1'b0;
          // A one-cycle long-press threshold is already met on entry.
          if (LONG_EN && (LONG_LAST == '0)) begin
            long_d      = 1'b1;
            long_done_d = 1'b1;
          end
        end else begin
          deb_cnt_d = deb_cnt_q + 32'd1;
        end
      end

      S_PRESSED: begin
        if (hold_cnt_q != LONG_LAST) begin
          hold_cnt_d = hold_cnt_q + 32'd1;
        end
        if (LONG_EN && !long_done_q && (hold_cnt_d == LONG_LAST)) begin
          long_d      = 1'b1;
          long_done_d = 1'b1;
        end
        if (!key_k) begin
          state_d   = S_REL_FILT;
          deb_cnt_d = '0;
        end
      end

      S_REL_FILT: begin
        // hold_cnt is frozen here; a bounce back to pressed resumes it and
        // keeps the long-press flag, so a glitch cannot re-arm the pulse.
        if (key_k) begin
          state_d = S_PRESSED;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d     = S_IDLE;
          release_d   = 1'b1;
          key_state_d = 1'b0;
        end else begin
          deb_cnt_d = deb_cnt_q + 32'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign o_key_state   = key_state_q;
  assign o_key_press   = press_q;
  assign o_key_release = release_q;
  assign o_long_press  = long_q;
  assign o_press_cnt   = press_cnt_q;

endmodule

// File: tb/tb_key_debounce.sv
// -----------------------------------------------------------------------------
// tb_key_debounce
//
// Two instances share clock and reset: dut_a is active-high with a 10-cycle
// long press, dut_b is active-low with long press disabled. Both use a
// 4-cycle debounce. A reference model expresses the filter as a run-length
// rule: a new level is accepted once the synchronised key has disagreed with
// the debounced level for DEB+1 consecutive edges. Press time accrues only
// on edges where no release is pending.
// -----------------------------------------------------------------------------
module tb_key_debounce;

  localparam int DEB = 4;

  logic clk = 1'b0;
  logic rst;
  logic key_a, key_b;

  logic       a_state, a_press, a_rel, a_long;
  logic [7:0] a_cnt;
  logic       b_state, b_press, b_rel, b_long;
  logic [7:0] b_cnt;

  logic [11:0] out_a, out_b;
  assign out_a = {a_state, a_press, a_rel, a_long, a_cnt};
  assign out_b = {b_state, b_press, b_rel, b_long, b_cnt};

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  key_debounce #(.P_KEY_ON(1'b1), .P_DEBOUNCE_CNT(DEB), .P_LONG_CNT(10)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_key(key_a),
    .o_key_state(a_state), .o_key_press(a_press), .o_key_release(a_rel),
    .o_long_press(a_long), .o_press_cnt(a_cnt)
  );

  key_debounce #(.P_KEY_ON(1'b0), .P_DEBOUNCE_CNT(DEB), .P_LONG_CNT(0)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_key(key_b),
    .o_key_state(b_state), .o_key_press(b_press), .o_key_release(b_rel),
    .o_long_press(b_long), .o_press_cnt(b_cnt)
  );

  // ---------------------------------------------------------------- model
  bit ON_LVL [2] = '{1'b1, 1'b0};
  int LONG   [2] = '{10, 0};

  bit pipe1 [2];
  bit pipe2 [2];
  bit lvl   [2];
  int run   [2];
  int held  [2];
  bit ldone [2];
  bit m_press [2];
  bit m_rel   [2];
  bit m_lp    [2];
  int m_cnt   [2];

  task automatic m_step(input int i, input logic pin);
    bit k;
    k        = pipe2[i];
    pipe2[i] = pipe1[i];
    pipe1[i] = (pin == ON_LVL[i]);
    m_press[i] = 1'b0;
    m_rel[i]   = 1'b0;
    m_lp[i]    = 1'b0;
    if (!lvl[i]) begin
      if (k) begin
        run[i]++;
        if (run[i] == DEB + 1) begin
          lvl[i]     = 1'b1;
          run[i]     = 0;
          m_press[i] = 1'b1;
          m_cnt[i]   = (m_cnt[i] + 1) % 256;
          held[i]    = 0;
          ldone[i]   = 1'b0;
          if (LONG[i] == 1) begin
            m_lp[i]  = 1'b1;
            ldone[i] = 1'b1;
          end
        end
      end else begin
        run[i] = 0;
      end
    end else begin
      if (run[i] == 0 && LONG[i] > 0) begin
        if (held[i] < LONG[i] - 1) held[i]++;
        if (held[i] == LONG[i] - 1 && !ldone[i]) begin
          m_lp[i]  = 1'b1;
          ldone[i] = 1'b1;
        end
      end
      if (!k) begin
        run[i]++;
        if (run[i] == DEB + 1) begin
          lvl[i]   = 1'b0;
          run[i]   = 0;
          m_rel[i] = 1'b1;
        end
      end else begin
        run[i] = 0;
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        pipe1[i] = 1'b0; pipe2[i] = 1'b0; lvl[i] = 1'b0;
        run[i] = 0; held[i] = 0; ldone[i] = 1'b0; m_cnt[i] = 0;
        m_press[i] = 1'b0; m_rel[i] = 1'b0; m_lp[i] = 1'b0;
      end
    end else begin
      m_step(0, key_a);
      m_step(1, key_b);
    end
  end

  function automatic logic [11:0] exp_vec(input int i);
    return {lvl[i], m_press[i], m_rel[i], m_lp[i], 8'(m_cnt[i])};
  endfunction

  // ---------------------------------------------------------------- stimulus
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst   = 1'b1;
    key_a = 1'b0;
    key_b = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    key_a = 1'b0;
    key_b = 1'b1;
    tick();
    tick();
    if ({out_a, out_b} !== 24'h0) begin
      errors++;
      $display("FAIL reset_values got %h want %h", {out_a, out_b}, 24'h0);
    end
    checks++;
    rst = 1'b0;
    for (int j = 0; j < 5; j++) begin
      tick();
      if ({out_a, out_b} !== 24'h0) begin
        errors++;
        $display("FAIL reset_release_quiet cyc %0d got %h want %h", j, {out_a, out_b}, 24'h0);
      end
      checks++;
    end
  endtask

  task automatic test_clean_press();
    apply_reset();
    for (int j = 0; j < 5; j++) tick();
    key_a = 1'b1;
    for (int j = 0; j < 30; j++) begin
      tick();
      if ({out_a, out_b} !== {exp_vec(0), exp_vec(1)}) begin
        errors++;
        $display("FAIL clean_model cyc %0d got %h want %h", j, {out_a, out_b}, {exp_vec(0), exp_vec(1)});
      end
      checks++;
      if ({a_press, a_state} !== {j == 6, j >= 6}) begin
        errors++;
        $display("FAIL clean_press cyc %0d got press=%b state=%b want %b %b", j, a_press, a_state, j == 6, j >= 6);
      end
      checks++;
    end
    key_a = 1'b0;
    for (int j = 0; j < 30; j++) begin
      tick();
      if ({out_a, out_b} !== {exp_vec(0), exp_vec(1)}) begin
        errors++;
        $display("FAIL clean_rel_model cyc %0d got %h want %h", j, {out_a, out_b}, {exp_vec(0), exp_vec(1)});
      end
      checks++;
      if ({a_rel, a_state} !== {j == 6, j < 6}) begin
        errors++;
        $display("FAIL clean_release cyc %0d got rel=%b state=%b want %b %b", j, a_rel, a_state, j == 6, j < 6);
      end
      checks++;
    end
    if (a_cnt !== 8'd1) begin
      errors++;
      $display("FAIL clean_count got %0d want 1", a_cnt);
    end
    checks++;
  endtask

  task automatic test_bounce();
    apply_reset();
    for (int j = 0; j < 30; j++) begin
      key_a = (j < 20) ? ((j % 4) != 3) : 1'b0;
      tick();
      if ({out_a, out_b} !== {exp_vec(0), exp_vec(1)}) begin
        errors++;
        $display("FAIL bounce_model cyc %0d got %h want %h", j, {out_a, out_b}, {exp_vec(0), exp_vec(1)});
      end
      checks++;
      if (out_a !== 12'h0) begin
        errors++;
        $display("FAIL bounce_quiet cyc %0d got %h want %h", j, out_a, 12'h0);
      end
      checks++;
    end
  endtask

  task automatic test_long_press();
    int n_press, n_long, n_rel;
    apply_reset();
    key_a = 1'b1;
    for (int j = 0; j < 25; j++) begin
      tick();
      if ({out_a, out_b} !== {exp_vec(0), exp_vec(1)}) begin
        errors++;
        $display("FAIL long_model cyc %0d got %h want %h", j, {out_a, out_b}, {exp_vec(0), exp_vec(1)});
      end
      checks++;
      if ({a_press, a_long} !== {j == 6, j == 15}) begin
        errors++;
        $display("FAIL long_timing cyc %0d got press=%b long=%b want %b %b", j, a_press, a_long, j == 6, j == 15);
      end
      checks++;
    end
    n_press = 0;
    n_long  = 0;
    for (int j = 0; j < 32; j++) begin
      key_a = (j >= 2);
      tick();
      if ({out_a, out_b} !== {exp_vec(0), exp_vec(1)}) begin
        errors++;
        $display("FAIL glitch_model cyc %0d got %h want %h", j, {out_a, out_b}, {exp_vec(0), exp_vec(1)});
      end
      checks++;
      n_press += int'(a_press);
      n_long  += int'(a_long);
    end
    if ({n_press, n_long} !== {32'd0, 32'd0} || a_state !== 1'b1) begin
      errors++;
      $display("FAIL glitch_no_repeat got press=%0d long=%0d state=%b want 0 0 1", n_press, n_long, a_state);
    end
    checks++;
    key_a = 1'b0;
    n_rel = 0;
    for (int j = 0; j < 15; j++) begin
      tick();
      n_rel += int'(a_rel);
    end
    if (n_rel !== 1 || a_state !== 1'b0 || a_cnt !== 8'd1) begin
      errors++;
      $display("FAIL long_final_release got rel=%0d state=%b cnt=%0d want 1 0 1", n_rel, a_state, a_cnt);
    end
    checks++;
  endtask

  task automatic test_reset_mid_press();
    apply_reset();
    for (int p = 0; p < 3; p++) begin
      key_a = 1'b1;
      for (int j = 0; j < 12; j++) tick();
      if (p < 2) begin
        key_a = 1'b0;
        for (int j = 0; j < 12; j++) tick();
      end
    end
    if ({a_state, a_cnt} !== {1'b1, 8'd3}) begin
      errors++;
      $display("FAIL midrst_setup got state=%b cnt=%0d want 1 3", a_state, a_cnt);
    end
    checks++;
    #2 rst = 1'b1;
    #1;
    if ({out_a, out_b} !== 24'h0) begin
      errors++;
      $display("FAIL midrst_async_clear got %h want %h", {out_a, out_b}, 24'h0);
    end
    checks++;
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 10; j++) begin
      tick();
      if ({out_a, out_b} !== {exp_vec(0), exp_vec(1)}) begin
        errors++;
        $display("FAIL midrst_model cyc %0d got %h want %h", j, {out_a, out_b}, {exp_vec(0), exp_vec(1)});
      end
      checks++;
      if (a_press !== (j == 6)) begin
        errors++;
        $display("FAIL midrst_repress cyc %0d got %b want %b", j, a_press, j == 6);
      end
      checks++;
    end
    if (a_cnt !== 8'd1) begin
      errors++;
      $display("FAIL midrst_count got %0d want 1", a_cnt);
    end
    checks++;
    key_a = 1'b0;
    for (int j = 0; j < 10; j++) tick();
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int p = 1; p <= 256; p++) begin
      key_a = 1'b1;
      for (int j = 0; j < 7; j++) begin
        tick();
        if ({out_a, out_b} !== {exp_vec(0), exp_vec(1)}) begin
          errors++;
          $display("FAIL wrap_model p %0d got %h want %h", p, {out_a, out_b}, {exp_vec(0), exp_vec(1)});
        end
        checks++;
      end
      if (a_cnt !== 8'(p % 256)) begin
        errors++;
        $display("FAIL wrap_count p %0d got %0d want %0d", p, a_cnt, p % 256);
      end
      checks++;
      key_a = 1'b0;
      for (int j = 0; j < 7; j++) tick();
    end
  endtask

  task automatic test_active_low();
    int n_long;
    apply_reset();
    for (int j = 0; j < 20; j++) begin
      tick();
      if (out_b !== 12'h0) begin
        errors++;
        $display("FAIL low_idle cyc %0d got %h want %h", j, out_b, 12'h0);
      end
      checks++;
    end
    key_b  = 1'b0;
    n_long = 0;
    for (int j = 0; j < 1000; j++) begin
      tick();
      if ({out_a, out_b} !== {exp_vec(0), exp_vec(1)}) begin
        errors++;
        $display("FAIL low_model cyc %0d got %h want %h", j, {out_a, out_b}, {exp_vec(0), exp_vec(1)});
      end
      checks++;
      if ({b_press, b_state} !== {j == 6, j >= 6}) begin
        errors++;
        $display("FAIL low_press cyc %0d got press=%b state=%b want %b %b", j, b_press, b_state, j == 6, j >= 6);
      end
      checks++;
      n_long += int'(b_long);
    end
    if (n_long !== 0) begin
      errors++;
      $display("FAIL low_no_long got %0d pulses want 0", n_long);
    end
    checks++;
    key_b = 1'b1;
    for (int j = 0; j < 10; j++) begin
      tick();
      if (b_rel !== (j == 6)) begin
        errors++;
        $display("FAIL low_release cyc %0d got %b want %b", j, b_rel, j == 6);
      end
      checks++;
    end
    if ({b_state, b_cnt} !== {1'b0, 8'd1}) begin
      errors++;
      $display("FAIL low_count got state=%b cnt=%0d want 0 1", b_state, b_cnt);
    end
    checks++;
  endtask

  task automatic test_random();
    int rem_a, rem_b;
    apply_reset();
    rem_a = 0;
    rem_b = 0;
    for (int j = 0; j < 3000; j++) begin
      if (rem_a == 0) begin
        key_a = 1'($urandom_range(0, 1));
        rem_a = $urandom_range(1, 12);
      end
      if (rem_b == 0) begin
        key_b = 1'($urandom_range(0, 1));
        rem_b = $urandom_range(1, 12);
      end
      rem_a--;
      rem_b--;
      tick();
      if ({out_a, out_b} !== {exp_vec(0), exp_vec(1)}) begin
        errors++;
        $display("FAIL random_model cyc %0d got %h want %h", j, {out_a, out_b}, {exp_vec(0), exp_vec(1)});
      end
      checks++;
    end
  endtask

  initial begin
    rst   = 1'b1;
    key_a = 1'b0;
    key_b = 1'b1;
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_press();
    test_reset_mid_press();
    test_wrap();
    test_active_low();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
# key_debounce

Single-key input conditioner for the board push-buttons: synchronises the raw pin, filters contact bounce with a counter-based state machine, and produces clean level and one-cycle event outputs. It sits between the button pins and user logic, for example the LED blink/toggle control, which consumes its press, release and long-press pulses. It is the input-side counterpart of the LED output driver.

## Interface
Parameters:
- P_KEY_ON, 1: pin level meaning "pressed" (0 or 1).
- P_DEBOUNCE_CNT, 20000: consecutive stable cycles required to accept a press or release; ≥1.
- P_LONG_CNT, 1000000: cycles held in PRESSED before the long-press event fires; 0 disables long press.

Ports:
- i_clk  input  1  system clock.
- i_rst  input  1  reset, asynchronous, active-high.
- i_key  input  1  raw, asynchronous button pin.
- o_key_state  output  1  debounced level, 1 = pressed.
- o_key_press  output  1  one-cycle pulse on an accepted press.
- o_key_release  output  1  one-cycle pulse on an accepted release.
- o_long_press  output  1  one-cycle pulse, at most once per press.
- o_press_cnt  output  8  count of accepted presses, wraps 255→0.

## Operation
- Synchroniser: two flops sample i_key. Both reset to ~P_KEY_ON (released), so reset release never produces a spurious press. Call the second flop's value, normalised to 1 = pressed, "k".
- Debounce counter: 32-bit. Hold counter: 32-bit, saturating.
- FSM states: IDLE, PRESS_FILT, PRESSED, REL_FILT.
  - IDLE: if k=1, go to PRESS_FILT and set deb_cnt=0.
  - PRESS_FILT:
    - k=0: return to IDLE, no output.
    - k=1 and deb_cnt==P_DEBOUNCE_CNT-1: go to PRESSED, pulse o_key_press, set o_key_state=1, increment o_press_cnt, set hold_cnt=0.
    - Otherwise: deb_cnt+1.
  - PRESSED:
    - hold_cnt increments each cycle and saturates at P_LONG_CNT-1.
    - When hold_cnt==P_LONG_CNT-1 is first reached and P_LONG_CNT≠0: pulse o_long_press once. A flag blocks re-firing until the next press.
    - k=0: go to REL_FILT and set deb_cnt=0.
  - REL_FILT:
    - k=1: return to PRESSED with no pulses. hold_cnt resumes from its frozen value; the long-press flag is kept.
    - k=0 and deb_cnt==P_DEBOUNCE_CNT-1: go to IDLE, pulse o_key_release, set o_key_state=0.
    - Otherwise: deb_cnt+1. hold_cnt is frozen in this state.
- o_long_press and o_key_release cannot coincide, because long press only fires in PRESSED.
- All outputs are registered.

## Timing
- Reset values:
  - Outputs: o_key_state=0, o_key_press=0, o_key_release=0, o_long_press=0, o_press_cnt=0.
  - Internal: state=IDLE, counters=0, long-press flag=0.
- Press latency: i_key is first sampled pressed at edge N and stays stable. PRESS_FILT is entered at edge N+2. o_key_press and o_key_state rise at edge N+2+P_DEBOUNCE_CNT. The pulse is exactly 1 cycle wide.
- Release latency: identical and symmetric, with o_key_release rising at edge N+2+P_DEBOUNCE_CNT.
- Long press: o_long_press rises P_LONG_CNT-1 edges after o_key_press rises, counting only cycles spent in PRESSED.
- Bounce: any glitch of at most P_DEBOUNCE_CNT-1 synchronised cycles during filtering aborts the filter and produces no event. The counter restarts from 0 on the next qualifying entry.
- Reset asserted mid-operation: all outputs clear immediately (asynchronous) and the FSM returns to IDLE. A key still held at reset release must pass the full PRESS_FILT again and is counted as a new press.

## Test plan
Test parameters: P_DEBOUNCE_CNT=4, P_LONG_CNT=10, P_KEY_ON=1, unless stated otherwise.

- Clean press/release:
  - i_key 0→1 sampled at edge 10, held for 30 cycles, then 1→0 sampled at edge 40.
  - Required: o_key_press high only in the cycle after edge 16. o_key_state=1 from edge 16. o_key_release high only after edge 46. o_press_cnt=1.
- Bounce rejection:
  - i_key pattern 1,1,1,0 repeated 5 times, then 0.
  - Required: no pulses, o_key_state stays 0, o_press_cnt=0.
- Long press with release bounce:
  - Hold the key; o_long_press fires 9 edges after o_key_press.
  - Inject a 2-cycle release glitch, then continue holding.
  - Required: no second o_long_press and no extra o_key_press.
  - On final release: exactly one o_key_release.
- Reset mid-press:
  - Assert i_rst while in PRESSED with o_press_cnt=3.
  - Required: all outputs go to 0 asynchronously.
  - Release i_rst with the key still held: o_key_press fires 6 edges later and o_press_cnt=1.
- Counter wrap:
  - 256 clean presses.
  - Required: o_press_cnt goes 255→0 on the 256th press.
- Active-low key and long press disabled:
  - P_KEY_ON=0, P_LONG_CNT=0.
  - Required: a 0 level on the pin is treated as a press. Out of reset with i_key=1 there are no events. o_long_press never asserts, including with a key hold of 1000 cycles.
